// File: rtl/core_clk_pkg.sv
// Shared types and encodings for the core clock-enable generator.
// Imported by the phase counter and the top-level sequencer.
package core_clk_pkg;

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_RUN,
        ST_HALT,
        ST_STEP_RUN
    } state_t;

    localparam logic [1:0] MODE_RUN  = 2'd0;
    localparam logic [1:0] MODE_HALT = 2'd1;
    localparam logic [1:0] MODE_STEP = 2'd2;

    localparam int MIN_DIV = 2;

endpackage

// File: rtl/tick_phase_counter.sv
// Phase counter with boundary reload of the divide ratio.
// Emits registered mid-period and end-of-period strobes.
module tick_phase_counter
    import core_clk_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [DIV_W-1:0] div_ratio_i,
    output logic             wrap_o,
    output logic             reg_tick_o,
    output logic             cpu_tick_o
);

    logic [DIV_W-1:0] phase_q, phase_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] div_eff, half_m1, last;
    logic             reg_tick_q, cpu_tick_q;
    logic             mid;

    // Ratios below two would give no room for separate strobes
    always_comb begin
        div_eff = (div_q < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : div_q;
        half_m1 = (div_eff >> 1) - DIV_W'(1);
        last    = div_eff - DIV_W'(1);
    end

    assign wrap_o = en_i && (phase_q == last);
    assign mid    = en_i && (phase_q == half_m1);

    always_comb begin
        phase_d = phase_q;
        div_d   = div_q;
        if (wrap_o) begin
            phase_d = '0;
            div_d   = div_ratio_i;
        end else if (en_i) begin
            phase_d = phase_q + DIV_W'(1);
        end
        if (load_i) begin
            div_d = div_ratio_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            phase_q    <= '0;
            div_q      <= DIV_W'(DEFAULT_DIV);
            reg_tick_q <= 1'b0;
            cpu_tick_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            div_q      <= div_d;
            reg_tick_q <= mid;
            cpu_tick_q <= wrap_o;
        end
    end

    assign reg_tick_o = reg_tick_q;
    assign cpu_tick_o = cpu_tick_q;

endmodule

// File: rtl/core_tick_gen.sv
// Clock-enable generator: post-reset hold, run/halt/step sequencing
// and a retired-tick counter around the phase counter.
module core_tick_gen
    import core_clk_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 16,
    parameter int POR_CYCLES  = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [DIV_W-1:0] div_ratio,
    input  logic [1:0]       mode,
    input  logic             step_req,
    output logic             cpu_tick,
    output logic             reg_tick,
    output logic             core_rst_n,
    output logic             running,
    output logic [CNT_W-1:0] tick_count
);

    localparam int HOLD_W = (POR_CYCLES > 1) ? $clog2(POR_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(POR_CYCLES - 1);

    state_t            state_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic              core_rst_n_q;
    logic              running_q;
    logic [CNT_W-1:0]  tick_count_q, tick_count_d;
    logic              en, load, wrap;

    assign en   = (state_q == ST_RUN) || (state_q == ST_STEP_RUN);
    assign load = (state_q == ST_HALT);

    tick_phase_counter #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_phase (
        .clk         (clk),
        .resetn      (resetn),
        .en_i        (en),
        .load_i      (load),
        .div_ratio_i (div_ratio),
        .wrap_o      (wrap),
        .reg_tick_o  (reg_tick),
        .cpu_tick_o  (cpu_tick)
    );

    assign tick_count_d = wrap ? tick_count_q + CNT_W'(1) : tick_count_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_HOLD;
            hold_cnt_q   <= '0;
            core_rst_n_q <= 1'b0;
            running_q    <= 1'b0;
            tick_count_q <= '0;
        end else begin
            tick_count_q <= tick_count_d;
            unique case (state_q)
                ST_HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        core_rst_n_q <= 1'b1;
                        running_q    <= (mode == MODE_RUN);
                        state_q      <= (mode == MODE_RUN) ? ST_RUN
                                                           : ST_HALT;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                    end
                end
                ST_RUN: begin
                    if (wrap && (mode != MODE_RUN)) begin
                        state_q   <= ST_HALT;
                        running_q <= 1'b0;
                    end
                end
                // A step always lands in HALT; RUN resumes from there
                ST_STEP_RUN: begin
                    if (wrap) begin
                        state_q   <= ST_HALT;
                        running_q <= 1'b0;
                    end
                end
                ST_HALT: begin
                    if (mode == MODE_RUN) begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                    end else if ((mode == MODE_STEP) && step_req) begin
                        state_q   <= ST_STEP_RUN;
                        running_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= ST_HOLD;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign core_rst_n = core_rst_n_q;
    assign running    = running_q;
    assign tick_count = tick_count_q;

endmodule
